// File: rtl/rectangle128_rkey_store_pkg.sv
// RECTANGLE-128 round-key store: shared constants, FSM encoding
// and index-walk helpers for the encrypt/decrypt key order.
package rectangle128_pkg;

  localparam int NUM_KEYS = 26;
  localparam int KEY_W    = 64;
  localparam int ADDR_W   = 5;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_KEYS,
    ST_STREAM,
    ST_DONE
  } rk_state_e;

  localparam logic [ADDR_W-1:0] IDX_LO  = '0;
  localparam logic [ADDR_W-1:0] IDX_HI  = ADDR_W'(NUM_KEYS - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

  function automatic logic [ADDR_W-1:0] first_idx(
    input logic mode
  );
    return (mode == MODE_DEC) ? IDX_HI : IDX_LO;
  endfunction

  function automatic logic [ADDR_W-1:0] last_idx(
    input logic mode
  );
    return (mode == MODE_DEC) ? IDX_LO : IDX_HI;
  endfunction

  function automatic logic [ADDR_W-1:0] step_idx(
    input logic              mode,
    input logic [ADDR_W-1:0] idx
  );
    return (mode == MODE_DEC) ? idx - IDX_ONE
                              : idx + IDX_ONE;
  endfunction

endpackage

// File: rtl/rectangle128_rkey_store_if.sv
// Round-key store bus: key-schedule write port plus the
// valid/accept subkey stream towards the round engine.
interface rectangle128_rkey_store_if;
  import rectangle128_pkg::*;

  logic              Flush;
  logic              WE;
  logic [ADDR_W-1:0] WAddr;
  logic [KEY_W-1:0]  KeyIn;
  logic              KeyReady;
  logic              WrDrop;
  logic              Start;
  logic              Mode;
  logic              Busy;
  logic [KEY_W-1:0]  RKey;
  logic [ADDR_W-1:0] RIdx;
  logic              RKeyValid;
  logic              RKeyAccept;
  logic              Done;

  modport slave (
    input  Flush, WE, WAddr, KeyIn,
    input  Start, Mode, RKeyAccept,
    output KeyReady, WrDrop, Busy,
    output RKey, RIdx, RKeyValid, Done
  );

  modport master (
    output Flush, WE, WAddr, KeyIn,
    output Start, Mode, RKeyAccept,
    input  KeyReady, WrDrop, Busy,
    input  RKey, RIdx, RKeyValid, Done
  );

endinterface

// File: rtl/rectangle128_rkey_ram.sv
// Subkey array: one write port, combinational read, no reset.
// Ports: Clk, wr_en/wr_addr/wr_data, rd_addr -> rd_data.
module rectangle128_rkey_ram
  import rectangle128_pkg::*;
(
  input  logic              Clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [KEY_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [KEY_W-1:0]  rd_data
);

  logic [KEY_W-1:0] mem [NUM_KEYS];

  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rectangle128_rkey_store.sv
// Round-key store and sequencer: collects 26 subkeys, then streams
// them ascending (encrypt) or descending (decrypt). Ports: Clk, RstN, bus.
module rectangle128_rkey_store
  import rectangle128_pkg::*;
(
  input  logic                     Clk,
  input  logic                     RstN,
  rectangle128_rkey_store_if.slave bus
);

  rk_state_e state, state_n;

  logic [NUM_KEYS-1:0] written, written_n;
  logic                key_ready;
  logic                wr_drop;
  logic                mode_q;
  logic                in_range;
  logic                wr_en;
  logic                start_ok;

  logic                load;
  logic                vld_clr;
  logic [ADDR_W-1:0]   rd_idx;
  logic [KEY_W-1:0]    rd_data;

  logic [KEY_W-1:0]    rkey;
  logic [ADDR_W-1:0]   ridx;
  logic                rvalid;

  assign in_range = bus.WAddr < ADDR_W'(NUM_KEYS);
  assign wr_en    = bus.WE & in_range & ~bus.Flush
                  & (state != ST_STREAM);
  assign start_ok = bus.Start & ~bus.Flush
                  & (state == ST_IDLE);

  rectangle128_rkey_ram u_ram (
    .Clk     (Clk),
    .wr_en   (wr_en),
    .wr_addr (bus.WAddr),
    .wr_data (bus.KeyIn),
    .rd_addr (rd_idx),
    .rd_data (rd_data)
  );

  always_comb begin
    written_n = written;
    if (bus.Flush) begin
      written_n = '0;
    end else if (wr_en) begin
      written_n = written | (NUM_KEYS'(1) << bus.WAddr);
    end
  end

  // KeyReady tracks the next bitmap so it rises with the completing write
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      written   <= '0;
      key_ready <= 1'b0;
      wr_drop   <= 1'b0;
      mode_q    <= MODE_ENC;
    end else begin
      written   <= written_n;
      key_ready <= &written_n;
      wr_drop   <= bus.WE & ~bus.Flush
                 & (~in_range | (state == ST_STREAM));
      if (start_ok) mode_q <= bus.Mode;
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    vld_clr = 1'b0;
    rd_idx  = '0;
    unique case (state)
      ST_IDLE: begin
        if (bus.Start) begin
          if (key_ready) begin
            state_n = ST_STREAM;
            load    = 1'b1;
            rd_idx  = first_idx(bus.Mode);
          end else begin
            state_n = ST_WAIT_KEYS;
          end
        end
      end
      ST_WAIT_KEYS: begin
        if (key_ready) begin
          state_n = ST_STREAM;
          load    = 1'b1;
          rd_idx  = first_idx(mode_q);
        end
      end
      ST_STREAM: begin
        if (rvalid & bus.RKeyAccept) begin
          if (ridx == last_idx(mode_q)) begin
            state_n = ST_DONE;
            vld_clr = 1'b1;
          end else begin
            load   = 1'b1;
            rd_idx = step_idx(mode_q, ridx);
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    if (bus.Flush) begin
      state_n = ST_IDLE;
      load    = 1'b0;
      vld_clr = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      rkey   <= '0;
      ridx   <= '0;
      rvalid <= 1'b0;
    end else if (load) begin
      rkey   <= rd_data;
      ridx   <= rd_idx;
      rvalid <= 1'b1;
    end else if (vld_clr) begin
      rvalid <= 1'b0;
    end
  end

  assign bus.KeyReady  = key_ready;
  assign bus.WrDrop    = wr_drop;
  assign bus.Busy      = (state == ST_WAIT_KEYS)
                       | (state == ST_STREAM);
  assign bus.RKey      = rkey;
  assign bus.RIdx      = ridx;
  assign bus.RKeyValid = rvalid;
  assign bus.Done      = (state == ST_DONE);

endmodule

// File: doc/rectangle128_rkey_store.md
# rectangle128_rkey_store

Round-key store and sequencer for the RECTANGLE-128 core. It sits between the key-schedule generator and the round datapath. The write side accepts the 26 generated 64-bit subkeys over a WE/WAddr/KeyIn memory interface. The read side streams them to the round engine over a valid/accept handshake, in ascending order for encryption and descending order for decryption.

## Interface
- `NUM_KEYS`, 26, number of subkeys stored (indices 0..NUM_KEYS-1).
- `KEY_W`, 64, subkey width.
- `ADDR_W`, 5, index/address width.
- `Clk`  in  1  single clock, rising edge.
- `RstN`  in  1  reset, asynchronous assert, active low.
- `Flush`  in  1  active-high synchronous clear of the written-bitmap; aborts any stream.
- `WE`  in  1  write strobe.
- `WAddr`  in  ADDR_W  write index.
- `KeyIn`  in  KEY_W  subkey data.
- `KeyReady`  out  1  all NUM_KEYS entries written since the last reset/Flush.
- `WrDrop`  out  1  one-cycle pulse: a write was discarded.
- `Start`  in  1  one-cycle request to stream the key set.
- `Mode`  in  1  sampled with Start: 0 = encrypt (0→25), 1 = decrypt (25→0).
- `Busy`  out  1  high in WAIT_KEYS and STREAM.
- `RKey`  out  KEY_W  current subkey (registered).
- `RIdx`  out  ADDR_W  index of RKey.
- `RKeyValid`  out  1  RKey/RIdx valid.
- `RKeyAccept`  in  1  consumer takes RKey when RKeyValid & RKeyAccept.
- `Done`  out  1  one-cycle pulse after the last key is accepted.

## Operation
- Storage: NUM_KEYS × KEY_W array, not reset. A written[NUM_KEYS-1:0] bitmap is cleared by reset and by Flush. KeyReady = &written, registered.
- Write is performed when WE=1, WAddr<NUM_KEYS, state≠STREAM and Flush=0. It writes the array entry and sets written[WAddr]. Rewriting an entry is allowed.
- WrDrop pulses on the cycle after a WE that was discarded because of an out-of-range address or because state=STREAM. WE together with Flush is silently discarded: no WrDrop.
- FSM states: IDLE, WAIT_KEYS, STREAM, DONE.
  - IDLE --Start--> STREAM if KeyReady=1, else WAIT_KEYS. Mode is latched on Start.
  - WAIT_KEYS --KeyReady--> STREAM. Writes are still accepted in this state.
  - STREAM: the first key is loaded on entry. On each accept, the next key is loaded (idx+1 for encrypt, idx-1 for decrypt). The accept of the last index (25 for encrypt, 0 for decrypt) moves to DONE.
  - DONE: Done=1 for one cycle, then IDLE.
- Start outside IDLE is ignored.
- Flush in any state: next state IDLE, RKeyValid=0, written cleared, no Done. Flush has priority over Start and over accept.
- RKey is the registered output of the array read. Its value is held stable while RKeyValid=1 and RKeyAccept=0.

## Timing
- Reset values: KeyReady=0, WrDrop=0, Busy=0, RKey=0, RIdx=0, RKeyValid=0, Done=0, state=IDLE.
- Write at cycle t: written bit visible at t+1; KeyReady rises at t+1 for the completing write.
- Start at t with KeyReady=1: RKeyValid=1 with the first key at t+1.
- Start at t with KeyReady=0: the first key appears 1 cycle after KeyReady rises.
- Accept at t (not last): next key on RKey at t+1. With accept held high, all 26 keys stream back-to-back over 26 cycles.
- Last accept at t: RKeyValid=0, Busy=0 and Done=1 at t+1; IDLE at t+2. A new Start is honoured from t+2.
- Reset mid-stream: all outputs return to reset values immediately (asynchronous); the array contents are undefined to the consumer until rewritten.

## Structure
- Shared package `rectangle128_pkg`: NUM_KEYS, KEY_W, ADDR_W, FSM state encoding, and the MODE_ENC=0 / MODE_DEC=1 constants. The RC table is not needed here.
- One sub-module, `rectangle128_rkey_ram`: 1-write/1-read array, combinational read, no reset. The FSM, bitmap and output register live in the top.

## Test plan
- Write keys k_i = {16'hA5A5, 43'h0, i[4:0]} for i=0..25, then Start with Mode=0 and RKeyAccept=1 → RIdx 0..25 on 26 consecutive cycles with matching RKey, Done one cycle after idx 25.
- Same key set, Start with Mode=1 → RIdx 25,24,…,0 with matching RKey; a Start issued during the stream is ignored.
- Backpressure: accept asserted only on odd cycles → each key held stable until accepted, 52 cycles total, no key skipped or duplicated.
- Start after only 20 writes → Busy=1, RKeyValid=0. Write entries 20..25 → first key appears 1 cycle after KeyReady rises.
- Flush at the 10th accepted key → RKeyValid=0 next cycle, no Done, KeyReady=0. A following Start waits in WAIT_KEYS.
- Dropped writes: WAddr=27 with WE=1 → WrDrop pulse, no bitmap change. WE during STREAM → WrDrop pulse and the stored value is unchanged on the next stream.
